// File: rtl/mo_pixel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mo_pixel_shifter                                              |
// | Purpose  : Serialises 4-plane 8-pixel graphics slices into palette+pixel |
// |            words for the MO line buffer. Optional macro                  |
// |            MO_SHIFT_HOLD_REG_EN adds a one-deep slice hold register.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mo_pixel_shifter (
    input  logic        MCKR,
    input  logic        RESET,
    input  logic        GLD_b,
    input  logic [31:0] MGRD,
    input  logic        MOHFLIP,
    input  logic [2:0]  MOPAL,
    output logic [6:0]  MOSR,
    output logic        MOACT,
    output logic        READY,
    output logic        OVR
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0]  pal;
        logic        flip;
        logic [31:0] data;
    } slice_t;

    localparam logic [6:0] C_IDLE_SR = 7'b000_1111;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    slice_t     r_sh;
    slice_t     w_sh_nxt;
    logic       r_ovr;
    logic       w_ovr_nxt;

    slice_t     w_in;
    logic       w_load;
    logic       w_last;
    logic       w_ready;
    logic       w_accept;
    logic [2:0] w_bit;
    logic [3:0] w_pix;

`ifdef MO_SHIFT_HOLD_REG_EN
    slice_t     r_hold;
    slice_t     w_hold_nxt;
    logic       r_hold_vld;
    logic       w_hold_vld_nxt;
`endif

    assign w_in   = '{pal: MOPAL, flip: MOHFLIP, data: MGRD};
    assign w_load = ~GLD_b;
    assign w_last = (r_state == ST_SHIFT) && (r_cnt == 3'd7);

`ifdef MO_SHIFT_HOLD_REG_EN
    // At LAST the hold slice moves into the shifter, so the hold slot frees up.
    assign w_ready = ~r_hold_vld | w_last;
`else
    assign w_ready = (r_state == ST_IDLE) | w_last;
`endif

    assign w_accept = w_load & w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_sh;
        w_ovr_nxt   = r_ovr | (w_load & ~w_ready);
`ifdef MO_SHIFT_HOLD_REG_EN
        w_hold_nxt     = r_hold;
        w_hold_vld_nxt = r_hold_vld;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_sh_nxt    = w_in;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_cnt_nxt = r_cnt + 3'd1;
                if (w_last) begin
`ifdef MO_SHIFT_HOLD_REG_EN
                    if (r_hold_vld) begin
                        w_sh_nxt       = r_hold;
                        w_hold_vld_nxt = w_accept;
                        if (w_accept) begin
                            w_hold_nxt = w_in;
                        end
                    end else if (w_accept) begin
                        w_sh_nxt = w_in;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`else
                    if (w_accept) begin
                        w_sh_nxt = w_in;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`endif
                end
`ifdef MO_SHIFT_HOLD_REG_EN
                else if (w_accept) begin
                    w_hold_nxt     = w_in;
                    w_hold_vld_nxt = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge MCKR) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_sh    <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sh    <= w_sh_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

`ifdef MO_SHIFT_HOLD_REG_EN
    always_ff @(posedge MCKR) begin
        if (RESET) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
        end else begin
            r_hold     <= w_hold_nxt;
            r_hold_vld <= w_hold_vld_nxt;
        end
    end
`endif

    // Unflipped slices emit the MSB of each plane first.
    assign w_bit = r_sh.flip ? r_cnt : (3'd7 - r_cnt);
    assign w_pix = {r_sh.data[{2'd3, w_bit}], r_sh.data[{2'd2, w_bit}],
                    r_sh.data[{2'd1, w_bit}], r_sh.data[{2'd0, w_bit}]};

    assign MOACT = (r_state == ST_SHIFT);
    assign MOSR  = MOACT ? {r_sh.pal, w_pix} : C_IDLE_SR;
    assign READY = w_ready;
    assign OVR   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_mo_pixel_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mo_pixel_shifter                                           |
// | Purpose  : Self-checking bench for mo_pixel_shifter against a queue-based |
// |            reference model of the emitted pixel stream.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mo_pixel_shifter;

    logic        MCKR;
    logic        RESET;
    logic        GLD_b;
    logic [31:0] MGRD;
    logic        MOHFLIP;
    logic [2:0]  MOPAL;
    logic [6:0]  MOSR;
    logic        MOACT;
    logic        READY;
    logic        OVR;

    mo_pixel_shifter dut (
        .MCKR    (MCKR),
        .RESET   (RESET),
        .GLD_b   (GLD_b),
        .MGRD    (MGRD),
        .MOHFLIP (MOHFLIP),
        .MOPAL   (MOPAL),
        .MOSR    (MOSR),
        .MOACT   (MOACT),
        .READY   (READY),
        .OVR     (OVR)
    );

    initial MCKR = 1'b0;
    always #5 MCKR = ~MCKR;

`ifdef MO_SHIFT_HOLD_REG_EN
    // Current slice (1..8 pixels left) plus a full hold slice still accepts at LAST.
    localparam int C_CAP = 9;
`else
    localparam int C_CAP = 1;
`endif

    int         n_cmp;
    int         n_err;
    logic [6:0] q_exp[$];
    logic       m_ovr;
    logic       last_act;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pix_of(input logic [31:0] d, input logic fl, input int i);
        int         b;
        logic [3:0] p;
        b = fl ? i : 7 - i;
        for (int k = 0; k < 4; k++) p[k] = d[8*k + b];
        return p;
    endfunction

    // One clock: drive inputs, compare outputs with the model, advance both.
    task automatic step(input logic ld, input logic [31:0] d, input logic fl,
                        input logic [2:0] pl, input logic rs);
        logic acc;
        GLD_b   = ~ld;
        MGRD    = d;
        MOHFLIP = fl;
        MOPAL   = pl;
        RESET   = rs;
        #1;
        chk("MOACT", {31'd0, MOACT}, {31'd0, q_exp.size() > 0});
        chk("MOSR", {25'd0, MOSR}, {25'd0, (q_exp.size() > 0) ? q_exp[0] : 7'h0F});
        chk("READY", {31'd0, READY}, {31'd0, q_exp.size() <= C_CAP});
        chk("OVR", {31'd0, OVR}, {31'd0, m_ovr});
        last_act = MOACT;
        if (rs) begin
            q_exp.delete();
            m_ovr = 1'b0;
        end else begin
            acc = ld && (q_exp.size() <= C_CAP);
            if (ld && !acc) m_ovr = 1'b1;
            if (q_exp.size() > 0) void'(q_exp.pop_front());
            if (acc) for (int i = 0; i < 8; i++) q_exp.push_back({pl, pix_of(d, fl, i)});
        end
        @(posedge MCKR);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'($urandom), 3'($urandom), 1'b0);
    endtask

    int act_cnt;

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_ovr = 1'b0;
        last_act = 1'b0;
        RESET = 1'b1;
        GLD_b = 1'b1;
        MGRD = '0;
        MOHFLIP = 1'b0;
        MOPAL = '0;
        @(posedge MCKR);
        #1;
        step(1'b0, 32'h0, 1'b0, 3'd0, 1'b0);

        // Single slice, plane0 = A5, palette 5
        step(1'b1, 32'h0000_00A5, 1'b0, 3'd5, 1'b0);
        chk("a5_pix0", {25'd0, MOSR}, {25'd0, 7'h51});
        idle(9);
        chk("a5_idle", {25'd0, MOSR}, 32'h0F);

        // Bit 0 set: first pixel only when flipped
        step(1'b1, 32'h0000_0001, 1'b1, 3'd2, 1'b0);
        chk("flip_pix0", {25'd0, MOSR}, 32'h21);
        idle(9);
        step(1'b1, 32'h0000_0001, 1'b0, 3'd2, 1'b0);
        chk("noflip_pix0", {25'd0, MOSR}, 32'h20);
        idle(9);

        // Loads exactly 8 cycles apart run back to back
        act_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(i == 0 || i == 8, $urandom, 1'($urandom), (i == 0) ? 3'd1 : 3'd6, 1'b0);
            if (last_act) act_cnt++;
        end
        chk("b2b_active", act_cnt, 16);

        // Loads at 0, 2, 4
        for (int i = 0; i < 24; i++)
            step(i == 0 || i == 2 || i == 4, $urandom, 1'($urandom), 3'($urandom), 1'b0);
        chk("ovr_set", {31'd0, OVR}, 32'd1);

        // Reset mid-slice at pixel 3
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 3'd3, 1'b0);
        idle(3);
        step(1'b0, 32'h0, 1'b0, 3'd0, 1'b1);
        chk("rst_mosr", {25'd0, MOSR}, 32'h0F);
        chk("rst_act", {31'd0, MOACT}, 32'd0);
        chk("rst_ovr", {31'd0, OVR}, 32'd0);
        chk("rst_ready", {31'd0, READY}, 32'd1);

        // Reset together with a load
        step(1'b1, 32'h1234_5678, 1'b0, 3'd7, 1'b1);
        chk("rstld_act", {31'd0, MOACT}, 32'd0);
        chk("rstld_ovr", {31'd0, OVR}, 32'd0);
        idle(9);

        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 2) == 0, $urandom, 1'($urandom), 3'($urandom),
                 $urandom_range(0, 149) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
